// File: rtl/mem_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bridge_if
//  Description : Bundles the core-side paged bus and the 16-bit memory-port
//                request/acknowledge signals used by mem_bridge.
//                slave  = bridge view, master = environment (core + memory).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_bridge_if #(
    parameter int ADDR_W = 22
);
    // core side
    logic [19:0]       c_addr;
    logic [15:0]       c_wdata;
    logic              c_read;
    logic              c_write;
    logic              c_instr;
    logic              c_read_done;
    logic [15:0]       c_rdata;
    logic [31:0]       c_instr_data;
    logic              c_busy;
    logic              c_ready;
    logic              c_cack;
    // memory side
    logic [ADDR_W-1:0] m_addr;
    logic [15:0]       m_wdata;
    logic              m_req;
    logic              m_we;
    logic [15:0]       m_rdata;
    logic              m_ack;
    // status
    logic              err;

    modport slave (
        input  c_addr, c_wdata, c_read, c_write, c_instr, c_read_done,
        input  m_rdata, m_ack,
        output c_rdata, c_instr_data, c_busy, c_ready, c_cack,
        output m_addr, m_wdata, m_req, m_we, err
    );

    modport master (
        output c_addr, c_wdata, c_read, c_write, c_instr, c_read_done,
        output m_rdata, m_ack,
        input  c_rdata, c_instr_data, c_busy, c_ready, c_cack,
        input  m_addr, m_wdata, m_req, m_we, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bridge
//  Description : Converts the core's paged 20-bit read/write bus into single
//                16-bit request/ack transactions on the memory port.
//                Instruction reads fetch two consecutive halves and present a
//                32-bit word {hi, lo}.
//                Optional macro MEM_BRIDGE_TIMEOUT_EN: abort a transaction
//                after TIMEOUT cycles without m_ack and raise sticky err.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bridge #(
    parameter int ADDR_W  = 22,
    parameter int TIMEOUT = 255
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_bridge_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Instruction space sits in the top half of the memory-port address map.
    localparam logic [ADDR_W-1:0] c_instr_base = {1'b1, {(ADDR_W-1){1'b0}}};

    state_t      r_state;
    state_t      w_next;

    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_instr;
    logic        r_write;
    logic        r_cack;
    logic [15:0] r_rdata;
    logic [31:0] r_idata;

    logic        w_req;
    logic        w_busy;
    logic        w_half;
    logic        w_timeout;

    assign w_req  = bus.c_read | bus.c_write;
    assign w_busy = (r_state == LO) || (r_state == HI);
    assign w_half = (r_state == HI);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = LO;
                end
            end
            LO: begin
                if (bus.m_ack) begin
                    if (r_write) begin
                        w_next = IDLE;
                    end else if (r_instr) begin
                        w_next = HI;
                    end else begin
                        w_next = HOLD;
                    end
                end else if (w_timeout) begin
                    w_next = r_write ? IDLE : HOLD;
                end
            end
            HI: begin
                if (bus.m_ack || w_timeout) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                // Leaving HOLD never starts a new request in the same cycle.
                if (bus.c_read_done || !bus.c_read) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, accept pulse and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_instr <= 1'b0;
            r_write <= 1'b0;
            r_cack  <= 1'b0;
            r_rdata <= '0;
            r_idata <= '0;
        end else begin
            r_cack <= (r_state == IDLE) && w_req;
            if ((r_state == IDLE) && w_req) begin
                r_addr  <= bus.c_addr;
                r_wdata <= bus.c_wdata;
                r_instr <= bus.c_instr;
                r_write <= bus.c_write;   // write wins a read/write collision
            end
            if ((r_state == LO) && !r_write) begin
                if (bus.m_ack) begin
                    if (r_instr) begin
                        r_idata[15:0] <= bus.m_rdata;
                    end else begin
                        r_rdata <= bus.m_rdata;
                    end
                end else if (w_timeout) begin
                    // Neither half has arrived yet, so both are poisoned.
                    if (r_instr) begin
                        r_idata <= 32'hFFFF_FFFF;
                    end else begin
                        r_rdata <= 16'hFFFF;
                    end
                end
            end
            if (r_state == HI) begin
                if (bus.m_ack) begin
                    r_idata[31:16] <= bus.m_rdata;
                end else if (w_timeout) begin
                    r_idata[31:16] <= 16'hFFFF;
                end
            end
        end
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    assign w_timeout = w_busy && !bus.m_ack && (r_cnt == c_timeout_last);
    assign bus.err   = r_err;

    // Ack-wait counter, restarted on every entry to LO/HI, and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_timeout;
            if ((w_next != r_state) && ((w_next == LO) || (w_next == HI))) begin
                r_cnt <= '0;
            end else if (w_busy && !bus.m_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
`else
    // No abort path: the bridge waits for m_ack indefinitely and TIMEOUT
    // has no effect on the result.
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0 & (TIMEOUT != 0);
`endif

    // Outputs are decoded from the registered state so m_req falls the
    // cycle after m_ack and immediately after a reset edge.
    assign bus.m_req        = w_busy;
    assign bus.m_we         = (r_state == LO) && r_write;
    assign bus.m_wdata      = r_wdata;
    assign bus.m_addr       = r_instr ? (c_instr_base | ADDR_W'({r_addr, w_half}))
                                      : ADDR_W'(r_addr);
    assign bus.c_busy       = w_busy;
    assign bus.c_ready      = (r_state == HOLD);
    assign bus.c_cack       = r_cack;
    assign bus.c_rdata      = r_rdata;
    assign bus.c_instr_data = r_idata;

endmodule
`default_nettype wire

// File: doc/mem_bridge.md
# mem_bridge

Downstream stage of the CPU core: converts the core's paged 20-bit memory bus (read/write strobes, instruction-access flag, read-done) into single-word request/acknowledge transactions on the 16-bit SDRAM/memory port. It produces the core's `busy`/`ready`/`cack` handshake and 16-bit data. For instruction fetches it also assembles 32-bit instruction words from two consecutive 16-bit reads.

## Interface
- `ADDR_W`, 22: memory-port word address width. Must be ≥ 22.
- `TIMEOUT`, 255: ack-wait limit in cycles, used only with `MEM_BRIDGE_TIMEOUT_EN`. 8-bit counter.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `c_addr`  in  20  paged address from core.
- `c_wdata`  in  16  write data from core.
- `c_read`  in  1  read request; level, held by core.
- `c_write`  in  1  write request; level, held by core.
- `c_instr`  in  1  instruction-space access; sampled with the request.
- `c_read_done`  in  1  core has consumed read data.
- `c_rdata`  out  16  data read result.
- `c_instr_data`  out  32  instruction read result, `{hi_word, lo_word}`.
- `c_busy`  out  1  transaction in progress.
- `c_ready`  out  1  read data valid.
- `c_cack`  out  1  one-cycle pulse: request accepted, address/data latched.
- `m_addr`  out  ADDR_W  memory word address.
- `m_wdata`  out  16  memory write data.
- `m_req`  out  1  memory request; held until `m_ack`.
- `m_we`  out  1  write qualifier for `m_req`.
- `m_rdata`  in  16  memory read data; valid in the `m_ack` cycle.
- `m_ack`  in  1  one-cycle completion from memory.
- `err`  out  1  sticky timeout flag. Constant 0 when the timeout feature is off.

## Operation
- States: `IDLE`, `LO`, `HI`, `HOLD`.
- Address mapping:
  - Data access: `m_addr = {ADDR_W-20 zeros, c_addr}`.
  - Instruction access: `m_addr = {1'b1, zeros, c_addr, half}`. `half` is 0 for the low word and 1 for the high word.
- `IDLE` → `LO` when `c_read | c_write` is high.
  - Latch address, data, `c_instr`, and operation.
  - If both `c_read` and `c_write` are high, write wins.
  - Pulse `c_cack` for one cycle.
- `LO`:
  - `m_req = 1`; `m_we = 1` for writes.
  - On `m_ack`, a write goes to `IDLE`.
  - On `m_ack`, a data read stores `m_rdata` into `c_rdata` and goes to `HOLD`.
  - On `m_ack`, an instruction read stores `m_rdata` into `c_instr_data[15:0]` and goes to `HI`.
- `HI`:
  - `m_req = 1`, `half = 1`.
  - On `m_ack`, store `m_rdata` into `c_instr_data[31:16]` and go to `HOLD`.
- `HOLD`:
  - `c_ready = 1`.
  - Leave to `IDLE` on `c_read_done`, or on `c_read` deasserting.
  - A new request is not accepted in the same cycle it leaves `HOLD`.
- `c_busy` is 1 in `LO` and `HI`, and 0 in `IDLE` and `HOLD`.
- `m_req` drops in the cycle after `m_ack` (registered). The memory must not ack twice per request.
- `c_rdata` and `c_instr_data` hold their last value until overwritten by a later read.
- Request inputs are ignored outside `IDLE`. Changes to `c_addr`/`c_wdata` during a transaction have no effect.

## Timing
- Reset values:
  - State `IDLE`.
  - `m_req`, `m_we`, `c_busy`, `c_ready`, `c_cack`, `err` = 0.
  - `c_rdata` = 0, `c_instr_data` = 0, `m_addr` = 0, `m_wdata` = 0.
- Reset mid-transaction returns to `IDLE` next edge and drops `m_req` immediately. A late `m_ack` in `IDLE` is ignored.
- Cycle-level sequence:
  - Request seen at edge N gives `c_cack` and `c_busy` high in cycle N+1, with `m_req` high from N+1.
  - With `m_ack` at edge M, data is valid and `c_ready` is high from cycle M+1.
- Latency with zero-wait memory (ack in the first `m_req` cycle):
  - Data read: request to `c_ready` in 2 cycles.
  - Instruction read: request to `c_ready` in 3 cycles.
  - Write: bridge back in `IDLE` 2 cycles after the request.

## Configuration
- `MEM_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to `LO`/`HI` and increments each cycle without `m_ack`.
  - At `TIMEOUT` the transaction aborts: `m_req` drops and `err` is set (sticky until `rst`).
  - A read abort loads `16'hFFFF` into the pending word(s) and goes to `HOLD`.
  - A write abort goes to `IDLE`.
- `MEM_BRIDGE_TIMEOUT_EN` undefined:
  - No counter; the bridge waits for `m_ack` indefinitely.
  - `err` is tied to 0.

## Test plan
- Data write:
  - Stimulus: `c_write`, `c_addr=20'h0_1234`, `c_wdata=16'hBEEF`, ack after 3 cycles.
  - Response: `m_addr=22'h001234`, `m_we=1`, `m_wdata=16'hBEEF`, one `c_cack` pulse, `c_ready` never high.
- Data read:
  - Stimulus: `c_read`, `c_addr=20'hF_0010`, `m_rdata=16'hA5A5` with immediate ack.
  - Response: `c_ready` 2 cycles after the request, `c_rdata=16'hA5A5`; `c_read_done` returns the bridge to `IDLE`.
- Instruction read:
  - Stimulus: `c_instr=1`, `c_addr=20'h0_0004`, words `16'h1111` then `16'h2222`.
  - Response: `m_addr` equals `{1,zeros,20'h00004,0}` then `{…,1}`; `c_instr_data=32'h2222_1111`.
- Write/read collision:
  - Stimulus: `c_read` and `c_write` high together.
  - Response: write performed; no `c_ready`.
- Reset mid-instruction read:
  - Stimulus: `rst` asserted in `HI`.
  - Response: `m_req=0` next cycle, all outputs at reset values; a stray `m_ack` causes no state change.
- Timeout (with `MEM_BRIDGE_TIMEOUT_EN`, `TIMEOUT=4`):
  - Stimulus: read with no ack.
  - Response: abort after 4 cycles, `c_rdata=16'hFFFF`, `c_ready=1`, `err=1` until `rst`.
